// File: rtl/rf2_port_arbiter.sv
// Port controller for a 1W/1R register file: clears the array after reset, then round-robin
// arbitrates two write clients and two read clients. Optional same-address bypass: RF2_ARB_BYPASS_EN.
module rf2_port_arbiter #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           wr_valid,
  output logic [1:0]           wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr0,
  input  logic [ADDR_BITS-1:0] wr_addr1,
  input  logic [DATA_BITS-1:0] wr_data0,
  input  logic [DATA_BITS-1:0] wr_data1,
  input  logic [1:0]           rd_valid,
  output logic [1:0]           rd_ready,
  input  logic [ADDR_BITS-1:0] rd_addr0,
  input  logic [ADDR_BITS-1:0] rd_addr1,
  output logic [1:0]           rd_rsp_valid,
  output logic [DATA_BITS-1:0] rd_rsp_data,
  output logic                 init_done,
  output logic                 rf_we,
  output logic [ADDR_BITS-1:0] rf_waddr,
  output logic [DATA_BITS-1:0] rf_wdata,
  output logic [ADDR_BITS-1:0] rf_raddr,
  input  logic [DATA_BITS-1:0] rf_q
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                 init_done_q, init_done_d;

  logic                 wr_sel, rd_sel;
  logic                 wr_go, rd_go;
  logic                 wr_in_range, rd_in_range;
  logic [ADDR_BITS-1:0] wr_addr_sel, rd_addr_sel;
  logic [DATA_BITS-1:0] wr_data_sel, rd_value;

  always_comb begin
    // On contention the pointer picks the winner; otherwise the lone requester wins.
    wr_sel      = (wr_valid == 2'b11) ? wr_ptr_q : wr_valid[1];
    rd_sel      = (rd_valid == 2'b11) ? rd_ptr_q : rd_valid[1];
    wr_go       = (state_q == ST_RUN) && !reset && (wr_valid != 2'b00);
    rd_go       = (state_q == ST_RUN) && !reset && (rd_valid != 2'b00);
    wr_addr_sel = wr_sel ? wr_addr1 : wr_addr0;
    wr_data_sel = wr_sel ? wr_data1 : wr_data0;
    rd_addr_sel = rd_sel ? rd_addr1 : rd_addr0;
    wr_in_range = (wr_addr_sel <= LAST_ADDR);
    rd_in_range = (rd_addr_sel <= LAST_ADDR);

    rd_value = rd_in_range ? rf_q : '0;
`ifdef RF2_ARB_BYPASS_EN
    if (wr_go && wr_in_range && rd_in_range && (wr_addr_sel == rd_addr_sel)) begin
      rd_value = wr_data_sel;
    end
`endif

    wr_ready = wr_go ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    rd_ready = rd_go ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    rf_raddr = rd_addr_sel;

    if (state_q == ST_INIT) begin
      rf_we    = !reset;
      rf_waddr = cnt_q;
      rf_wdata = '0;
    end else begin
      rf_we    = wr_go && wr_in_range;
      rf_waddr = wr_addr_sel;
      rf_wdata = wr_data_sel;
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_valid == 2'b11) wr_ptr_d = ~wr_ptr_q;
        if (rd_valid == 2'b11) rd_ptr_d = ~rd_ptr_q;
        if (rd_go) begin
          rsp_valid_d = rd_ready;
          rsp_data_d  = rd_value;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = rsp_data_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_rf2_port_arbiter.sv
// Bench for rf2_port_arbiter: a register-file harness, a cycle-level behavioural model with a
// per-cycle compare process, directed literal checks and a randomized traffic phase.
module tb_rf2_port_arbiter;
  localparam int DEPTH = 16;
  localparam int AW    = 7;
  localparam int DW    = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rd_rsp_valid;
  logic [AW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1, rf_waddr, rf_raddr;
  logic [DW-1:0] wr_data0, wr_data1, rd_rsp_data, rf_wdata, rf_q;
  logic          init_done, rf_we;

  int errors = 0;
  int checks = 0;

  rf2_port_arbiter dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .init_done(init_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_q(rf_q)
  );

  always #5 clk = ~clk;

  // Register-file harness with random power-up contents; out-of-range reads return garbage.
  logic [DW-1:0] rf_mem [DEPTH];
  logic          preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= DW'($urandom);
      preloaded <= 1'b1;
    end else if (rf_we && (rf_waddr < AW'(DEPTH))) begin
      rf_mem[rf_waddr[3:0]] <= rf_wdata;
    end
  end

  assign rf_q = (rf_raddr < AW'(DEPTH)) ? rf_mem[rf_raddr[3:0]] : 13'h1ABC;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, cycles since reset, and who wins the next tie.
  int            m_since = 0;
  bit            m_wturn = 1'b0;
  bit            m_rturn = 1'b0;
  logic [1:0]    m_rv = 2'b00;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] m_mem [DEPTH];

  function automatic int pick(input logic [1:0] v, input bit turn);
    if (v == 2'b11) return turn ? 1 : 0;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  always begin : model_proc
    int            wg, rg, n_since;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, n_rd;
    logic [1:0]    n_rv;
    bit            w_in, r_in, do_write, do_clear, n_wturn, n_rturn;

    @(negedge clk);
    do_write = 1'b0;
    do_clear = 1'b0;
    n_wturn  = m_wturn;
    n_rturn  = m_rturn;
    n_rv     = 2'b00;
    n_rd     = m_rd;
    n_since  = m_since;
    wa       = '0;
    wd       = '0;
    if (reset) begin
      checkOutput("m_rst_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("m_rst_rd_ready", 32'(rd_ready), 32'd0);
      checkOutput("m_rst_rf_we", 32'(rf_we), 32'd0);
      n_since = 0;
      n_wturn = 1'b0;
      n_rturn = 1'b0;
      n_rd    = '0;
    end else if (m_since < DEPTH) begin
      checkOutput("m_init_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("m_init_rd_ready", 32'(rd_ready), 32'd0);
      checkOutput("m_init_rf_we", 32'(rf_we), 32'd1);
      checkOutput("m_init_rf_waddr", 32'(rf_waddr), 32'(m_since));
      checkOutput("m_init_rf_wdata", 32'(rf_wdata), 32'd0);
      checkOutput("m_init_rsp_valid", 32'(rd_rsp_valid), 32'd0);
      checkOutput("m_init_rsp_data", 32'(rd_rsp_data), 32'(m_rd));
      checkOutput("m_init_done", 32'(init_done), 32'd0);
      do_clear = 1'b1;
      n_since  = m_since + 1;
    end else begin
      wg   = pick(wr_valid, m_wturn);
      rg   = pick(rd_valid, m_rturn);
      wa   = (wg == 1) ? wr_addr1 : wr_addr0;
      wd   = (wg == 1) ? wr_data1 : wr_data0;
      ra   = (rg == 1) ? rd_addr1 : rd_addr0;
      w_in = (wa < AW'(DEPTH));
      r_in = (ra < AW'(DEPTH));
      checkOutput("m_wr_ready", 32'(wr_ready), (wg < 0) ? 32'd0 : 32'(1 << wg));
      checkOutput("m_rd_ready", 32'(rd_ready), (rg < 0) ? 32'd0 : 32'(1 << rg));
      do_write = (wg >= 0) && w_in;
      checkOutput("m_rf_we", 32'(rf_we), 32'(do_write));
      if (do_write) begin
        checkOutput("m_rf_waddr", 32'(rf_waddr), 32'(wa));
        checkOutput("m_rf_wdata", 32'(rf_wdata), 32'(wd));
      end
      if (rg >= 0) checkOutput("m_rf_raddr", 32'(rf_raddr), 32'(ra));
      checkOutput("m_rsp_valid", 32'(rd_rsp_valid), 32'(m_rv));
      checkOutput("m_rsp_data", 32'(rd_rsp_data), 32'(m_rd));
      checkOutput("m_init_done_run", 32'(init_done), 32'd1);
      if (rg >= 0) begin
        n_rv = 2'(1 << rg);
        n_rd = r_in ? m_mem[ra[3:0]] : '0;
`ifdef RF2_ARB_BYPASS_EN
        if (do_write && r_in && (wa == ra)) n_rd = wd;
`endif
      end
      if (wr_valid == 2'b11) n_wturn = ~m_wturn;
      if (rd_valid == 2'b11) n_rturn = ~m_rturn;
    end
    @(posedge clk);
    if (do_clear) m_mem[m_since[3:0]] = '0;
    if (do_write) m_mem[wa[3:0]] = wd;
    m_since = n_since;
    m_wturn = n_wturn;
    m_rturn = n_rturn;
    m_rv    = n_rv;
    m_rd    = n_rd;
  end

  task automatic applyStimulus(input logic [1:0] wv, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                               input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                               input logic [1:0] rv, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_valid = wv; wr_addr0 = wa0; wr_data0 = wd0; wr_addr1 = wa1; wr_data1 = wd1;
    rd_valid = rv; rd_addr0 = ra0; rd_addr1 = ra1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string name, input int client, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp);
    applyStimulus(2'b00, '0, '0, '0, '0, (client == 1) ? 2'b10 : 2'b01, addr, addr);
    tick();
    checkOutput({name, "_valid"}, 32'(rd_rsp_valid), (client == 1) ? 32'd2 : 32'd1);
    checkOutput({name, "_data"}, 32'(rd_rsp_data), 32'(exp));
    applyStimulus(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] exp_entry;
    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("init_first_we", 32'(rf_we), 32'd1);
    checkOutput("init_first_waddr", 32'(rf_waddr), 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("init_done_cycle16", 32'(init_done), 32'd0);
    tick();
    checkOutput("init_done_cycle17", 32'(init_done), 32'd1);

    for (int i = 0; i < DEPTH; i++) readCheck("clear_read", i % 2, AW'(i), 13'h000);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 7'd3, 13'h0AA, 7'd5, 13'h155, 2'b00, '0, '0);
      @(negedge clk);
      checkOutput("contention_grant", 32'(wr_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    readCheck("contention_rd3", 0, 7'd3, 13'h0AA);
    readCheck("latency_rd5", 1, 7'd5, 13'h155);
    tick();
    checkOutput("latency_n2_valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("latency_n2_hold", 32'(rd_rsp_data), 32'h155);

    applyStimulus(2'b01, 7'd20, 13'h1FFF, '0, '0, 2'b00, '0, '0);
    @(negedge clk);
    checkOutput("oor_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("oor_rf_we", 32'(rf_we), 32'd0);
    tick();
    readCheck("oor_read", 0, 7'd20, 13'h000);
    for (int i = 0; i < DEPTH; i++) begin
      exp_entry = (i == 3) ? 13'h0AA : (i == 5) ? 13'h155 : 13'h000;
      readCheck("oor_unchanged", 0, AW'(i), exp_entry);
    end

    applyStimulus(2'b01, 7'd7, 13'h001, '0, '0, 2'b00, '0, '0);
    tick();
    applyStimulus(2'b01, 7'd7, 13'h123, '0, '0, 2'b01, 7'd7, '0);
    tick();
`ifdef RF2_ARB_BYPASS_EN
    checkOutput("collision_rsp", 32'(rd_rsp_data), 32'h123);
`else
    checkOutput("collision_rsp", 32'(rd_rsp_data), 32'h001);
`endif
    readCheck("collision_later", 1, 7'd7, 13'h123);

    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        applyStimulus(2'b11, 7'd2, 13'h0F0, 7'd9, 13'h00F, 2'b11, 7'd2, 7'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
        checkOutput("midrst_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("midrst_rd_ready", 32'(rd_ready), 32'd0);
        checkOutput("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("midrst_init_done", 32'(init_done), 32'd0);
        tick();
      end else begin
        applyStimulus(2'($urandom), AW'($urandom_range(0, 19)), DW'($urandom),
                      AW'($urandom_range(0, 19)), DW'($urandom),
                      2'($urandom), AW'($urandom_range(0, 19)), AW'($urandom_range(0, 19)));
        tick();
      end
    end

    applyStimulus(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf2_port_arbiter.md
# rf2_port_arbiter

Port controller for a 1-write/1-read register file: 16 entries × 13 bits, combinational read, write on the clock edge. It clears the array after reset, then shares the single write port between two write clients and the single read port between two read clients. Each port uses independent round-robin arbitration with valid/ready handshakes. Read responses are registered and returned to the requesting client one cycle after acceptance. It sits between the register file instance and the pipeline stages that use it.

## Interface
Parameters:
- DEPTH, 16, number of register-file entries
- ADDR_BITS, 7, address width (addresses ≥ DEPTH are out of range)
- DATA_BITS, 13, data width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous active-high reset
- wr_valid  in  2  write request per client (bit i = client i)
- wr_ready  out  2  write accepted when wr_valid[i] & wr_ready[i]
- wr_addr0, wr_addr1  in  ADDR_BITS  write address per client
- wr_data0, wr_data1  in  DATA_BITS  write data per client
- rd_valid  in  2  read request per client
- rd_ready  out  2  read accepted when rd_valid[i] & rd_ready[i]
- rd_addr0, rd_addr1  in  ADDR_BITS  read address per client
- rd_rsp_valid  out  2  one-cycle response strobe per client
- rd_rsp_data  out  DATA_BITS  response data, valid when any rd_rsp_valid bit is set
- init_done  out  1  high once the clear sweep has completed
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_BITS  register-file write address
- rf_wdata  out  DATA_BITS  register-file write data
- rf_raddr  out  ADDR_BITS  register-file read address
- rf_q  in  DATA_BITS  register-file combinational read data

## Operation
- State machine with two states:
  - INIT: clears the array; both ports are closed.
  - RUN: normal arbitration.
- Reset forces INIT and clears the clear counter, both round-robin pointers, the response registers and init_done.
- INIT behaviour:
  - rf_we=1, rf_waddr=counter, rf_wdata=0. The counter steps 0..DEPTH-1, one entry per cycle.
  - wr_ready=rd_ready=0.
  - After writing entry DEPTH-1, transition to RUN and set init_done=1. init_done stays high until the next reset.
- Write arbitration in RUN:
  - If exactly one wr_valid bit is set, that client is granted.
  - If both are set, the client named by wr_ptr is granted, and wr_ptr flips to the other client.
  - wr_ready is one-hot or zero; it is combinational from wr_valid and wr_ptr.
  - The granted request drives rf_we=1 and rf_waddr/rf_wdata combinationally.
- Out-of-range write (addr ≥ DEPTH): the request is accepted but rf_we stays 0, so nothing is written.
- Read arbitration uses the same rule with an independent rd_ptr. The granted address drives rf_raddr.
- On an accepted read:
  - rf_q (or 0 if addr ≥ DEPTH) is registered into rd_rsp_data.
  - The matching rd_rsp_valid bit is set for exactly one cycle.
  - Responses have no backpressure.
- When no read is accepted, rd_rsp_valid=0 and rd_rsp_data holds its previous value.
- A reset mid-operation aborts everything on the next edge: responses are dropped, pointers clear, and INIT restarts from entry 0.

## Timing
- Output values during reset and INIT: wr_ready=0, rd_ready=0, rd_rsp_valid=0, rd_rsp_data=0, init_done=0.
- rf_we during the reset cycle itself is 0.
- INIT lasts DEPTH cycles after reset deasserts. The first request can be accepted in cycle DEPTH+1.
- Write latency: the data is in the array at the edge that accepts the request.
- Read latency is 1 cycle: accepted at edge N, rd_rsp_valid is high during cycle N+1.
- Back-to-back: one write and one read can be accepted every cycle, sustained.
- Same-cycle read and write to the same address: the read returns the OLD contents, unless the bypass is enabled (see Configuration).

## Configuration
- Macro: RF2_ARB_BYPASS_EN.
- Defined: when an accepted read and an accepted in-range write target the same address in the same cycle, the response carries the NEW write data. This costs one address comparator and one data mux.
- Undefined: the response carries the OLD contents, i.e. rf_q as sampled at that edge.

## Test plan
- Reset clear: preload is irrelevant. Release reset and wait 16 cycles, then read all 16 entries. Required: init_done rises at cycle 16, and every response equals 0.
- Contention: both write clients are continuously valid (client0 addr 3 data 0x0AA, client1 addr 5 data 0x155) for 4 cycles. Required: grants alternate 0,1,0,1 starting from client0. Reads then return 0x0AA at addr 3 and 0x155 at addr 5.
- Read latency and routing: client1 reads addr 5 at edge N. Required: rd_rsp_valid=2'b10 and rd_rsp_data=0x155 in cycle N+1. In cycle N+2, rd_rsp_valid=0.
- Out-of-range access: a write to addr 20 with data 0x1FFF, then a read of addr 20. Required: the write is accepted with rf_we=0, the read returns 0, and entries 0..15 are unchanged.
- Read/write collision: write addr 7 = 0x123 in the same cycle as a read of addr 7, which holds 0x001. Required: the response is 0x001 without RF2_ARB_BYPASS_EN and 0x123 with it. A later read returns 0x123 in both builds.
- Mid-operation reset: assert reset for 1 cycle during streaming traffic. Required: the next cycle shows rd_rsp_valid=0 and ready=0, and the INIT sweep repeats for 16 cycles.
